mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single memory_controller port between three requesters: CPU (index 0), accelerator (index 1) and DMA FSM (index 2).
- Grants ownership round-robin, with bounded bursts.
- Tags every read so that in-order read responses are steered back to the requester that issued them.
- Sits between the requesters and memory_controller inside afu.

Parameters:
- DATA_WIDTH, 32, memory word width.
- ADDR_WIDTH, 28, memory word address width.
- MAX_BURST, 8, maximum beats per grant before forced rotation (1..255).
- TAG_DEPTH, 4, maximum number of outstanding reads; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  3  per-requester request/beat valid.
- we  in  3  per-requester write enable; 0 = read.
- addr  in  3*ADDR_WIDTH  packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  in  3*DATA_WIDTH  packed write data.
- gnt  out  3  one-hot grant/ready.
- rdata  out  DATA_WIDTH  read data, broadcast to all requesters.
- rvalid  out  3  one-hot read-data valid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_rvalid  in  1  memory read valid; responses arrive in order, latency at least 1.
- err  out  1  sticky error flag: a response arrived with no outstanding read.
- perf_cnt  out  3*32  per-requester beat counters (see Optional Feature).

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, owner=0, rr_ptr=0, beat_cnt=0, tag FIFO emptied, err=0, perf_cnt=0.
  - All outputs 0.
  - Reset mid-burst abandons the burst; responses still in flight at the memory are treated as unexpected.
- State IDLE:
  - gnt=0.
  - If any req is high, the winner is the first requester with req high, searching from rr_ptr upward mod 3.
  - owner<=winner, beat_cnt<=0, state<=GRANT.
  - Grant latency: req first seen in IDLE at cycle N gives gnt high at N+1.
- State GRANT:
  - gnt[owner] = !tag_full; all other gnt bits are 0 (combinational from registered state).
  - A beat fires in a cycle where req[owner] && gnt[owner].
  - On a beat: mem_en=1 and mem_we/mem_addr/mem_wdata are taken from owner's slice in the same cycle (combinational). Otherwise mem_en=0, mem_we=0 and mem_addr/mem_wdata are don't-care.
  - Beats are never issued for a non-owner.
- Leaving GRANT (go to IDLE, with rr_ptr<=(owner+1) mod 3):
  - req[owner] low in any cycle; or
  - a beat fires while beat_cnt==MAX_BURST-1.
  - Otherwise beat_cnt increments on each beat.
- Rotation between grants:
  - There is always at least one IDLE cycle (bubble) between two grants.
  - A requester that keeps req high re-competes at the lowest priority.
- Stalling on a full tag FIFO:
  - tag_full stalls both reads and writes of the owner: gnt drops, beat_cnt holds and ownership is kept.
  - req[owner] low during the stall still releases the grant.
- Tag FIFO:
  - Push owner ID on each read beat (mem_en && !mem_we).
  - Pop on mem_rvalid.
  - Simultaneous push and pop leaves the count unchanged and is legal at full.
- Read return:
  - rdata = mem_rdata.
  - rvalid[i] = mem_rvalid && !tag_empty && head_tag==i.
  - Zero added latency; all paths are combinational.
- Unexpected response: mem_rvalid while the FIFO is empty is dropped (rvalid=0) and sets err. err clears only on rst.
- Wrap-around: rr_ptr and the FIFO pointers wrap modulo 3 and modulo TAG_DEPTH respectively.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: perf_cnt[i*32 +: 32] counts beats issued for requester i, saturates at 32'hFFFF_FFFF, and resets on rst.
- Undefined: the counters are not built and perf_cnt is tied to 0. All other behaviour is identical.

Test Plan:
1. CPU alone: req=3'b001, we=0, addr=0x10, memory latency 2 -> gnt=001 one cycle after req; mem_en with mem_addr=0x10; rvalid=001 with rdata equal to the memory word 2 cycles after the beat.
2. All three request continuously after reset, MAX_BURST=8 -> grant order CPU, ACL, DMA, CPU, each grant exactly 8 beats, one bubble between grants.
3. DMA write burst of 3 beats, then req low -> exactly 3 mem_en with mem_we=1; state returns to IDLE; next grant goes to CPU (rr_ptr=0) if CPU is requesting.
4. ACL issues 4 reads with memory latency 10, TAG_DEPTH=4 -> gnt low after the 4th read until the first mem_rvalid; then gnt rises and the 5th read issues; rvalid=010 four times in order.
5. Interleaved reads from CPU then DMA, responses still in flight -> rvalid=001 for the CPU's responses, then rvalid=100 for the DMA's, matching issue order.
6. Assert rst mid-burst, then deliver one stale mem_rvalid -> all outputs 0, rvalid stays 0, err=1. With ARB_PERF_CNT_EN defined, perf_cnt reads 0 after reset and increments by 1 per subsequent beat.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory_controller port between CPU, accelerator and DMA,
// with bounded bursts and read-tag steering. Define ARB_PERF_CNT_EN to build per-requester beat counters.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 28,
  parameter int MAX_BURST  = 8,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              req,
  input  logic [2:0]              we,
  input  logic [3*ADDR_WIDTH-1:0] addr,
  input  logic [3*DATA_WIDTH-1:0] wdata,
  output logic [2:0]              gnt,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [2:0]              rvalid,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_rvalid,
  output logic                    err,
  output logic [3*32-1:0]         perf_cnt
);

  localparam int PTR_W = $clog2(TAG_DEPTH);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state, state_next;
  logic [1:0]              owner, owner_next;
  logic [1:0]              rr_ptr, rr_next;
  logic [7:0]              beat_cnt, beat_cnt_next;
  logic [1:0]              tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [PTR_W:0]          tag_cnt;
  logic                    tag_full, tag_empty;
  logic                    beat, push, pop;
  logic                    own_req, own_we;
  logic [ADDR_WIDTH-1:0]   own_addr;
  logic [DATA_WIDTH-1:0]   own_wdata;
  logic [1:0]              head_tag;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // First requesting index at or after p, wrapping modulo 3.
  function automatic logic [1:0] pick_winner(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] c1, c2;
    c1 = inc3(p);
    c2 = inc3(c1);
    if (r[p])       return p;
    else if (r[c1]) return c1;
    else            return c2;
  endfunction

  always_comb begin
    own_req   = req[0];
    own_we    = we[0];
    own_addr  = addr[0 +: ADDR_WIDTH];
    own_wdata = wdata[0 +: DATA_WIDTH];
    case (owner)
      2'd1: begin
        own_req   = req[1];
        own_we    = we[1];
        own_addr  = addr[ADDR_WIDTH +: ADDR_WIDTH];
        own_wdata = wdata[DATA_WIDTH +: DATA_WIDTH];
      end
      2'd2: begin
        own_req   = req[2];
        own_we    = we[2];
        own_addr  = addr[2*ADDR_WIDTH +: ADDR_WIDTH];
        own_wdata = wdata[2*DATA_WIDTH +: DATA_WIDTH];
      end
      default: ;
    endcase
  end

  assign tag_full  = (tag_cnt == (PTR_W+1)'(TAG_DEPTH));
  assign tag_empty = (tag_cnt == '0);
  assign head_tag  = tag_mem[rd_ptr];

  // A full tag FIFO withholds the grant for writes too, so ownership is simply paused.
  assign gnt       = (state == GRANT && !tag_full) ? (3'b001 << owner) : 3'b000;
  assign beat      = (state == GRANT) && own_req && !tag_full;
  assign mem_en    = beat;
  assign mem_we    = beat && own_we;
  assign mem_addr  = beat ? own_addr : '0;
  assign mem_wdata = beat ? own_wdata : '0;

  assign push   = beat && !own_we;
  assign pop    = mem_rvalid && !tag_empty;
  assign rdata  = mem_rdata;
  assign rvalid = pop ? (3'b001 << head_tag) : 3'b000;

  always_comb begin
    state_next    = state;
    owner_next    = owner;
    rr_next       = rr_ptr;
    beat_cnt_next = beat_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_next    = pick_winner(req, rr_ptr);
          beat_cnt_next = '0;
          state_next    = GRANT;
        end
      end
      GRANT: begin
        if (!own_req || (beat && beat_cnt == 8'(MAX_BURST - 1))) begin
          state_next = IDLE;
          rr_next    = inc3(owner);
        end else if (beat) begin
          beat_cnt_next = beat_cnt + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      rr_ptr   <= rr_next;
      beat_cnt <= beat_cnt_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
      if (mem_rvalid && tag_empty) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= owner;
  end

`ifdef ARB_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_q [3];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst)                           perf_q[i] <= '0;
      else if (beat && owner == 2'(i))   perf_q[i] <= sat_inc(perf_q[i]);
    end
  end

  assign perf_cnt = {perf_q[2], perf_q[1], perf_q[0]};
`else
  assign perf_cnt = '0;
`endif

endmodule
